// File: rtl/rv_load_store_unit.sv
// rv_load_store_unit
// ------------------
// Memory stage of an RV32 pipeline. Accepts one load/store per handshake
// from the execute stage, where the ALU sum is the effective address. It
// issues a single word-aligned request on a req/gnt/rvalid data port and
// returns the result (or an exception) to writeback through a
// valid/ready handshake.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   op handshake from execute (in_ready = unit idle)
//   in_is_load/store    op kind (both or neither set = illegal)
//   in_funct3           RV32 load/store funct3
//   in_addr             effective address
//   in_wdata            rs2 store value
//   in_rd               destination register
//   mem_req/we/addr     data-memory request (addr is word aligned)
//   mem_wstrb/wdata     byte strobes and lane-replicated store data
//   mem_gnt             request accepted
//   mem_rvalid/rdata    read response
//   out_valid/out_ready result handshake to writeback
//   out_wb_en           write out_data into out_rd (successful loads only)
//   out_data/out_rd     extended load data and destination register
//   out_misaligned      access not aligned to its size
//   out_illegal         bad funct3 or bad load/store combination
//   out_buserr          load response never arrived
//   out_badaddr         faulting address when an error flag is set, else 0
//
// Parameter
//   TIMEOUT             WAIT_R cycles before a bus error (0 = wait forever)

module rv_load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_wb_en,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_misaligned,
    output logic        out_illegal,
    output logic        out_buserr,
    output logic [31:0] out_badaddr
);

    // The counter only has to reach TIMEOUT-1 before the bus error fires.
    localparam int            CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
    localparam bit            TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_reg;
    logic          in_ready_reg;
    logic          is_store_reg;
    logic [2:0]    funct3_reg;
    logic [31:0]   addr_reg;
    logic [4:0]    rd_reg;
    logic [CW-1:0] wait_cnt_reg;

    logic          mem_req_reg;
    logic          mem_we_reg;
    logic [31:0]   mem_addr_reg;
    logic [3:0]    mem_wstrb_reg;
    logic [31:0]   mem_wdata_reg;

    logic          out_valid_reg;
    logic          out_wb_en_reg;
    logic [31:0]   out_data_reg;
    logic [4:0]    out_rd_reg;
    logic          out_misaligned_reg;
    logic          out_illegal_reg;
    logic          out_buserr_reg;
    logic [31:0]   out_badaddr_reg;

    // ------------------------------------------------------------------
    // Decode of the op presented at the input (used only on accept)
    // ------------------------------------------------------------------
    logic        acc_illegal;
    logic        acc_misaligned;
    logic [3:0]  acc_wstrb;
    logic [31:0] acc_wdata;

    always_comb begin
        acc_illegal = 1'b0;
        if (in_is_load == in_is_store) begin
            acc_illegal = 1'b1;
        end else if (in_is_load) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: acc_illegal = 1'b0;
                default:                                acc_illegal = 1'b1;
            endcase
        end else begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010: acc_illegal = 1'b0;
                default:                acc_illegal = 1'b1;
            endcase
        end

        // Access size lives in funct3[1:0] for both loads and stores.
        acc_misaligned = 1'b0;
        case (in_funct3[1:0])
            2'b01:   acc_misaligned = in_addr[0];
            2'b10:   acc_misaligned = |in_addr[1:0];
            default: acc_misaligned = 1'b0;
        endcase

        acc_wstrb = 4'b0000;
        acc_wdata = 32'h0;
        if (in_is_store) begin
            case (in_funct3[1:0])
                2'b00: begin
                    acc_wstrb = 4'b0001 << in_addr[1:0];
                    acc_wdata = {4{in_wdata[7:0]}};
                end
                2'b01: begin
                    acc_wstrb = 4'b0011 << in_addr[1:0];
                    acc_wdata = {2{in_wdata[15:0]}};
                end
                default: begin
                    acc_wstrb = 4'b1111;
                    acc_wdata = in_wdata;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load data extraction from the returned word
    // ------------------------------------------------------------------
    logic [7:0]  rd_byte [4];
    logic [1:0]  off_lo;
    logic [1:0]  off_hi;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Halfwords are aligned here, so off_hi never wraps for a real access.
    assign off_lo  = addr_reg[1:0];
    assign off_hi  = addr_reg[1:0] + 2'd1;
    assign ld_byte = rd_byte[off_lo];
    assign ld_half = {rd_byte[off_hi], rd_byte[off_lo]};

    always_comb begin
        case (funct3_reg)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            in_ready_reg       <= 1'b1;
            is_store_reg       <= 1'b0;
            funct3_reg         <= 3'b000;
            addr_reg           <= 32'h0;
            rd_reg             <= 5'd0;
            wait_cnt_reg       <= '0;
            mem_req_reg        <= 1'b0;
            mem_we_reg         <= 1'b0;
            mem_addr_reg       <= 32'h0;
            mem_wstrb_reg      <= 4'b0000;
            mem_wdata_reg      <= 32'h0;
            out_valid_reg      <= 1'b0;
            out_wb_en_reg      <= 1'b0;
            out_data_reg       <= 32'h0;
            out_rd_reg         <= 5'd0;
            out_misaligned_reg <= 1'b0;
            out_illegal_reg    <= 1'b0;
            out_buserr_reg     <= 1'b0;
            out_badaddr_reg    <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_reg <= 1'b0;
                        is_store_reg <= in_is_store;
                        funct3_reg   <= in_funct3;
                        addr_reg     <= in_addr;
                        rd_reg       <= in_rd;
                        if (acc_illegal || acc_misaligned) begin
                            // Illegal wins over misaligned; no bus traffic.
                            state_reg          <= DONE;
                            out_valid_reg      <= 1'b1;
                            out_rd_reg         <= in_rd;
                            out_illegal_reg    <= acc_illegal;
                            out_misaligned_reg <= ~acc_illegal;
                            out_badaddr_reg    <= in_addr;
                        end else begin
                            state_reg     <= REQ;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= in_is_store;
                            mem_addr_reg  <= {in_addr[31:2], 2'b00};
                            mem_wstrb_reg <= acc_wstrb;
                            mem_wdata_reg <= acc_wdata;
                        end
                    end
                end

                REQ: begin
                    // Request fields stay frozen until the grant.
                    if (mem_gnt) begin
                        mem_req_reg   <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        mem_wstrb_reg <= 4'b0000;
                        if (is_store_reg) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            out_rd_reg    <= rd_reg;
                        end else begin
                            state_reg    <= WAIT_R;
                            wait_cnt_reg <= '0;
                        end
                    end
                end

                WAIT_R: begin
                    if (mem_rvalid) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        out_wb_en_reg <= 1'b1;
                        out_data_reg  <= ld_ext;
                        out_rd_reg    <= rd_reg;
                    end else if (TIMEOUT_EN && (wait_cnt_reg == CNT_LAST)) begin
                        state_reg       <= DONE;
                        out_valid_reg   <= 1'b1;
                        out_rd_reg      <= rd_reg;
                        out_buserr_reg  <= 1'b1;
                        out_badaddr_reg <= addr_reg;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_reg          <= IDLE;
                        in_ready_reg       <= 1'b1;
                        out_valid_reg      <= 1'b0;
                        out_wb_en_reg      <= 1'b0;
                        out_data_reg       <= 32'h0;
                        out_rd_reg         <= 5'd0;
                        out_misaligned_reg <= 1'b0;
                        out_illegal_reg    <= 1'b0;
                        out_buserr_reg     <= 1'b0;
                        out_badaddr_reg    <= 32'h0;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_reg;
    assign mem_req        = mem_req_reg;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wstrb      = mem_wstrb_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign out_valid      = out_valid_reg;
    assign out_wb_en      = out_wb_en_reg;
    assign out_data       = out_data_reg;
    assign out_rd         = out_rd_reg;
    assign out_misaligned = out_misaligned_reg;
    assign out_illegal    = out_illegal_reg;
    assign out_buserr     = out_buserr_reg;
    assign out_badaddr    = out_badaddr_reg;

endmodule

// File: tb/tb_rv_load_store_unit.sv
// tb_rv_load_store_unit
// ---------------------
// Directed and random load/store ops driven against rv_load_store_unit
// (TIMEOUT=4). Expected results come from a behavioural model that works
// from access size and byte offset with plain arithmetic.

module tb_rv_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic        out_wb_en;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_misaligned;
    logic        out_illegal;
    logic        out_buserr;
    logic [31:0] out_badaddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv_load_store_unit #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_funct3      (in_funct3),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_rd          (in_rd),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wstrb      (mem_wstrb),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_wb_en      (out_wb_en),
        .out_data       (out_data),
        .out_rd         (out_rd),
        .out_misaligned (out_misaligned),
        .out_illegal    (out_illegal),
        .out_buserr     (out_buserr),
        .out_badaddr    (out_badaddr)
    );

    typedef struct packed {
        logic        illegal;
        logic        misaligned;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } exp_t;

    // Behavioural reference: size in bytes, offset in bytes, shifts and masks.
    function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rd);
        exp_t        e;
        int          size;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        e = '0;
        if (ld == st)  e.illegal = 1'b1;
        else if (ld)   e.illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else           e.illegal = !(f3 inside {3'd0, 3'd1, 3'd2});
        size = 1 << f3[1:0];
        off  = int'(addr[1:0]);
        if (!e.illegal) begin
            e.misaligned = ((off % size) != 0);
            if (st) begin
                e.wstrb = 4'(((1 << size) - 1) << off);
                for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end
            if (ld) begin
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 32'h1);
                v = (rd >> (8*off)) & mask;
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
                e.ldata = v;
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete op. gd = grant delay cycles, d = WAIT_R cycles before
    // rvalid (>=4 means never), rdy = cycles out_ready is held low.
    task automatic run_op(input string name, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input logic [4:0] rdn, input int gd, input int d,
                          input int rdy, input bit junk);
        exp_t        e;
        logic        err;
        logic        berr;
        logic        wb;
        logic [31:0] held;
        int          n;
        e    = model(ld, st, f3, addr, wd, rd);
        err  = e.illegal | e.misaligned;
        berr = ld && !st && !err && (d >= 4);
        wb   = ld && !st && !err && !berr;

        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({name, "/in_ready_idle"}, 32'(in_ready), 32'd1);

        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wd;
        in_rd       = rdn;
        step();
        in_valid = 1'b0;
        in_addr  = $urandom;
        in_wdata = $urandom;
        chk({name, "/in_ready_busy"}, 32'(in_ready), 32'd0);

        if (err) begin
            chk({name, "/no_req"}, 32'(mem_req), 32'd0);
        end else begin
            for (int g = 0; g <= gd; g++) begin
                chk({name, "/mem_req"}, 32'(mem_req), 32'd1);
                chk({name, "/mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                chk({name, "/mem_we"}, 32'(mem_we), 32'(st));
                chk({name, "/mem_wstrb"}, 32'(mem_wstrb), 32'(e.wstrb));
                if (st) chk({name, "/mem_wdata"}, mem_wdata, e.wdata);
                chk({name, "/early_valid"}, 32'(out_valid), 32'd0);
                mem_gnt = (g == gd);
                if (junk) begin
                    mem_rvalid = 1'($urandom);
                    mem_rdata  = $urandom;
                end
                step();
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
            end
            if (ld) begin
                for (int w = 0; w < 4; w++) begin
                    chk({name, "/wait_req_low"}, 32'(mem_req), 32'd0);
                    chk({name, "/wait_valid"}, 32'(out_valid), 32'd0);
                    if (w == d) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rd;
                    end
                    step();
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                    if (w == d) break;
                end
            end
        end

        chk({name, "/out_valid"}, 32'(out_valid), 32'd1);
        chk({name, "/illegal"}, 32'(out_illegal), 32'(e.illegal));
        chk({name, "/misaligned"}, 32'(out_misaligned), 32'(!e.illegal && e.misaligned));
        chk({name, "/buserr"}, 32'(out_buserr), 32'(berr));
        chk({name, "/wb_en"}, 32'(out_wb_en), 32'(wb));
        chk({name, "/out_rd"}, 32'(out_rd), 32'(rdn));
        chk({name, "/badaddr"}, out_badaddr, (err || berr) ? addr : 32'h0);
        if (wb) chk({name, "/out_data"}, out_data, e.ldata);
        held = out_data;

        for (int k = 0; k < rdy; k++) begin
            step();
            chk({name, "/hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "/hold_data"}, out_data, held);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "/released"}, 32'(out_valid), 32'd0);
        chk({name, "/ready_again"}, 32'(in_ready), 32'd1);

        $display("txn %s ld=%0b st=%0b f3=%0d addr=%08h ill=%0b mis=%0b berr=%0b wb=%0b data=%08h",
                 name, ld, st, f3, addr, e.illegal, e.misaligned, berr, wb, out_data);
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "/mem_req"}, 32'(mem_req), 32'd0);
        chk({name, "/out_valid"}, 32'(out_valid), 32'd0);
        chk({name, "/wb_en"}, 32'(out_wb_en), 32'd0);
        chk({name, "/flags"}, {29'd0, out_misaligned, out_illegal, out_buserr}, 32'd0);
        chk({name, "/out_data"}, out_data, 32'h0);
        chk({name, "/out_rd"}, 32'(out_rd), 32'd0);
        chk({name, "/badaddr"}, out_badaddr, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_funct3   = 3'd0;
        in_addr     = 32'h0;
        in_wdata    = 32'h0;
        in_rd       = 5'd0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        out_ready   = 1'b0;
        step();
        step();
        chk_cleared("reset");
        rst_n = 1'b1;
        step();
        chk("reset/in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op("SW",       1'b0, 1'b1, 3'd2, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,         5'd1, 0, 0, 0, 0);
        run_op("SB_off3",  1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0,         5'd2, 0, 0, 1, 0);
        run_op("SH_off2",  1'b0, 1'b1, 3'd1, 32'h0000_0402, 32'h1234_5678, 32'h0,         5'd3, 1, 0, 0, 1);
        run_op("LB",       1'b1, 1'b0, 3'd0, 32'h0000_0202, 32'h0,         32'h1180_3344, 5'd4, 0, 0, 0, 0);
        run_op("LBU",      1'b1, 1'b0, 3'd4, 32'h0000_0202, 32'h0,         32'h1180_3344, 5'd5, 0, 0, 0, 0);
        run_op("LH",       1'b1, 1'b0, 3'd1, 32'h0000_0202, 32'h0,         32'h1180_3344, 5'd6, 0, 0, 0, 0);
        run_op("LH_neg",   1'b1, 1'b0, 3'd1, 32'h0000_0200, 32'h0,         32'h1180_8344, 5'd7, 0, 1, 0, 1);
        run_op("LHU_neg",  1'b1, 1'b0, 3'd5, 32'h0000_0200, 32'h0,         32'h1180_8344, 5'd8, 0, 2, 0, 1);
        run_op("LW",       1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 5'd9, 2, 3, 2, 1);
        run_op("LW_mis",   1'b1, 1'b0, 3'd2, 32'h0000_0306, 32'h0,         32'h0,         5'd10, 0, 0, 0, 0);
        run_op("LD_ill",   1'b1, 1'b0, 3'd3, 32'h0000_0301, 32'h0,         32'h0,         5'd11, 0, 0, 0, 0);
        run_op("SBU_ill",  1'b0, 1'b1, 3'd4, 32'h0000_0300, 32'h0,         32'h0,         5'd12, 0, 0, 0, 0);
        run_op("both_ill", 1'b1, 1'b1, 3'd2, 32'h0000_0300, 32'h0,         32'h0,         5'd13, 0, 0, 0, 0);
        run_op("none_ill", 1'b0, 1'b0, 3'd0, 32'h0000_0300, 32'h0,         32'h0,         5'd14, 0, 0, 0, 0);
        run_op("LW_tmo",   1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'h0,         32'h0,         5'd15, 3, 9, 0, 0);

        // Random ops
        for (int t = 0; t < 150; t++) begin
            logic        ld;
            logic        st;
            logic [31:0] a;
            int          cat;
            cat = int'($urandom_range(0, 9));
            if (cat == 0) begin
                ld = 1'($urandom);
                st = ld;
            end else begin
                ld = (cat <= 5);
                st = !ld;
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_op("rand", ld, st, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                   5'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 2)), 1'b1);
        end

        // Reset while a load result waits for writeback
        in_valid    = 1'b1;
        in_is_load  = 1'b1;
        in_is_store = 1'b0;
        in_funct3   = 3'd2;
        in_addr     = 32'h0000_0600;
        in_rd       = 5'd20;
        step();
        in_valid = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A_0001;
        step();
        mem_rvalid = 1'b0;
        chk("rst_done/out_valid", 32'(out_valid), 32'd1);
        chk("rst_done/out_data", out_data, 32'h5A5A_0001);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rst_done/hold_valid", 32'(out_valid), 32'd1);
            chk("rst_done/hold_data", out_data, held);
        end
        rst_n = 1'b0;
        step();
        chk_cleared("rst_done");
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        chk_cleared("late_rvalid");
        chk("late_rvalid/in_ready", 32'(in_ready), 32'd1);
        $display("txn reset_in_done rd=20 addr=00000600");

        // Reset while the request is outstanding
        in_valid    = 1'b1;
        in_is_load  = 1'b0;
        in_is_store = 1'b1;
        in_funct3   = 3'd2;
        in_addr     = 32'h0000_0700;
        step();
        in_valid = 1'b0;
        chk("rst_req/mem_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rst_req/mem_req_after", 32'(mem_req), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_req/in_ready", 32'(in_ready), 32'd1);
        $display("txn reset_in_req addr=00000700");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
